multiplicador_suma: RTL and testbench

- Sequential shift-and-add reconstructor: computes dividendo = cociente * divisor + resto.
- Inverse of the restoring-division path; closes the loop on divider results (self-check, test support).
- Iterative, one quotient bit per clock, MSB-first (same bit order the divider produces quotient bits).
- Sits beside the divider stage chain; start/listo handshake to the controlling FSM.

---
 rtl/multiplicador_suma.sv | 151 +++++++++++++++
 tb/tb_multiplicador_suma.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_suma.sv
// multiplicador_suma: sequential shift-and-add reconstructor.
//   Computes dividendo = cociente * divisor + resto, one quotient bit per
//   clock, MSB first, then adds the remainder in a final cycle.
//   Latency: inicio sampled at edge T -> listo pulse and result after
//   edge T+N+1 (ocupado high for N+1 cycles).
// Optional macro: VERIFICA_RESTO_EN
//   When defined, error is registered on the final cycle as (resto >= divisor).
//   When undefined, error is tied low and no comparator exists.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   inicio     start request, sampled only when idle
//   cociente   quotient operand  [N-1:0]
//   divisor    divisor operand   [N-1:0]
//   resto      remainder operand [N-1:0]
//   dividendo  reconstructed dividend [2N-1:0], registered
//   ocupado    operation in progress
//   listo      one-cycle completion pulse
//   error      invalid (resto, divisor) tuple flag
module multiplicador_suma #(
  parameter int unsigned N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [N-1:0]     cociente,
  input  logic [N-1:0]     divisor,
  input  logic [N-1:0]     resto,
  output logic [2*N-1:0]   dividendo,
  output logic             ocupado,
  output logic             listo,
  output logic             error
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUMA   = 2'd1,
    RESTO  = 2'd2
  } estado_t;

  estado_t         r_estado, w_estado_sig;
  logic [N-1:0]    r_q, w_q;
  logic [N-1:0]    r_d, w_d;
  logic [N-1:0]    r_r, w_r;
  logic [W2-1:0]   r_acc, w_acc;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [W2-1:0]   r_dividendo, w_dividendo;
  logic            r_ocupado, w_ocupado;
  logic            r_listo, w_listo;
  logic [W2-1:0]   w_sumando;
`ifdef VERIFICA_RESTO_EN
  logic            r_error, w_error;
`endif

  // Partial product for the current quotient bit (divisor zero-extended)
  assign w_sumando = r_q[r_cnt] ? {{N{1'b0}}, r_d} : '0;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= REPOSO;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dividendo <= '0;
      r_ocupado   <= 1'b0;
      r_listo     <= 1'b0;
`ifdef VERIFICA_RESTO_EN
      r_error     <= 1'b0;
`endif
    end else begin
      r_estado    <= w_estado_sig;
      r_q         <= w_q;
      r_d         <= w_d;
      r_r         <= w_r;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
      r_dividendo <= w_dividendo;
      r_ocupado   <= w_ocupado;
      r_listo     <= w_listo;
`ifdef VERIFICA_RESTO_EN
      r_error     <= w_error;
`endif
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_estado_sig = r_estado;
    w_q          = r_q;
    w_d          = r_d;
    w_r          = r_r;
    w_acc        = r_acc;
    w_cnt        = r_cnt;
    w_dividendo  = r_dividendo;
    w_ocupado    = r_ocupado;
    w_listo      = 1'b0;
`ifdef VERIFICA_RESTO_EN
    w_error      = r_error;
`endif

    case (r_estado)
      REPOSO: begin
        if (inicio) begin
          w_q          = cociente;
          w_d          = divisor;
          w_r          = resto;
          w_acc        = '0;
          w_cnt        = CW'(N - 1);
          w_ocupado    = 1'b1;
          w_estado_sig = SUMA;
        end
      end
      SUMA: begin
        w_acc = (r_acc << 1) + w_sumando;
        w_cnt = r_cnt - CW'(1);
        // Bit 0 consumed on this edge: remainder add comes next
        if (r_cnt == '0) begin
          w_estado_sig = RESTO;
        end
      end
      RESTO: begin
        w_dividendo  = r_acc + {{N{1'b0}}, r_r};
        w_listo      = 1'b1;
        w_ocupado    = 1'b0;
        w_estado_sig = REPOSO;
`ifdef VERIFICA_RESTO_EN
        w_error      = (r_r >= r_d);
`endif
      end
      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  assign dividendo = r_dividendo;
  assign ocupado   = r_ocupado;
  assign listo     = r_listo;
`ifdef VERIFICA_RESTO_EN
  assign error     = r_error;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_multiplicador_suma.sv
// Directed testbench for multiplicador_suma (N=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multiplicador_suma;

  localparam int unsigned N = 4;

  logic           clk;
  logic           rst;
  logic           inicio;
  logic [N-1:0]   cociente;
  logic [N-1:0]   divisor;
  logic [N-1:0]   resto;
  logic [2*N-1:0] dividendo;
  logic           ocupado;
  logic           listo;
  logic           error;

  int errors = 0;
  int checks = 0;

  multiplicador_suma #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .cociente  (cociente),
    .divisor   (divisor),
    .resto     (resto),
    .dividendo (dividendo),
    .ocupado   (ocupado),
    .listo     (listo),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected error flag for a (resto, divisor) pair
  function automatic logic exp_err(input logic [N-1:0] r, input logic [N-1:0] d);
`ifdef VERIFICA_RESTO_EN
    return (r >= d);
`else
    return 1'b0;
`endif
  endfunction

  // Start one operation and wait for listo; lat = edges after the start edge
  task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d,
                        input logic [N-1:0] r, output int lat, output bit ok);
    @(negedge clk);
    cociente = q; divisor = d; resto = r; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    cociente = ~q; divisor = ~d; resto = ~r;
    lat = 0;
    ok  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (listo) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; inicio = 1'b0;
    cociente = '0; divisor = '0; resto = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dividendo, ocupado, listo, error} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got div=%0d ocu=%b lis=%b err=%b, need all 0",
               dividendo, ocupado, listo, error);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ocupado !== 1'b0 || listo !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ocu=%b lis=%b, need 0 0", ocupado, listo);
    end
  endtask

  // 3*5+2 with ocupado/listo timing and dividendo hold during the operation
  task automatic test_basico();
    int n_ocu;
    bit seen;
    logic [2*N-1:0] prev;
    prev = dividendo;
    @(negedge clk);
    cociente = 4'd3; divisor = 4'd5; resto = 4'd2; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0; cociente = 4'd15; divisor = 4'd15; resto = 4'd15;
    n_ocu = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (listo) begin
        seen = 1'b1;
        break;
      end
      if (ocupado) n_ocu++;
      checks++;
      if (dividendo !== prev) begin
        errors++;
        $display("FAIL basico_hold: got %0d mid-operation, need %0d", dividendo, prev);
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basico_timeout: got no listo, need listo within 20 cycles");
    end
    checks++;
    if (n_ocu != N + 1) begin
      errors++;
      $display("FAIL basico_ocupado_cycles: got %0d, need %0d", n_ocu, N + 1);
    end
    checks++;
    if (dividendo !== 8'd17 || ocupado !== 1'b0 || error !== exp_err(4'd2, 4'd5)) begin
      errors++;
      $display("FAIL basico_result: got div=%0d ocu=%b err=%b, need div=17 ocu=0 err=%b",
               dividendo, ocupado, error, exp_err(4'd2, 4'd5));
    end
    @(negedge clk);
    checks++;
    if (listo !== 1'b0 || dividendo !== 8'd17) begin
      errors++;
      $display("FAIL basico_listo_pulse: got lis=%b div=%0d, need lis=0 div=17", listo, dividendo);
    end
  endtask

  // Directed single operation with latency and value checks
  task automatic test_op(input string name, input logic [N-1:0] q, input logic [N-1:0] d,
                         input logic [N-1:0] r, input logic [2*N-1:0] exp_div);
    int lat;
    bit ok;
    run_op(q, d, r, lat, ok);
    checks++;
    if (!ok || lat != N + 1) begin
      errors++;
      $display("FAIL %s_latency: got ok=%0d lat=%0d, need ok=1 lat=%0d", name, ok, lat, N + 1);
    end
    checks++;
    if (dividendo !== exp_div || error !== exp_err(r, d)) begin
      errors++;
      $display("FAIL %s_result: got div=%0d err=%b, need div=%0d err=%b",
               name, dividendo, error, exp_div, exp_err(r, d));
    end
  endtask

  // inicio during SUMA ignored, then inicio in the listo cycle accepted
  task automatic test_back_to_back();
    int lat;
    bit ok;
    @(negedge clk);
    cociente = 4'd9; divisor = 4'd3; resto = 4'd1; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    cociente = 4'd15; divisor = 4'd15; resto = 4'd15; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (listo) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || dividendo !== 8'd28 || error !== exp_err(4'd1, 4'd3)) begin
      errors++;
      $display("FAIL ignorar_inicio: got ok=%0d div=%0d err=%b, need ok=1 div=28 err=%b",
               ok, dividendo, error, exp_err(4'd1, 4'd3));
    end
    // Request in the listo cycle
    cociente = 4'd2; divisor = 4'd6; resto = 4'd5; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accepted: got ocu=%b, need 1", ocupado);
    end
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (listo) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!ok || lat != N + 1 || dividendo !== 8'd17 || error !== exp_err(4'd5, 4'd6)) begin
      errors++;
      $display("FAIL b2b_result: got ok=%0d lat=%0d div=%0d err=%b, need ok=1 lat=%0d div=17 err=%b",
               ok, lat, dividendo, error, N + 1, exp_err(4'd5, 4'd6));
    end
  endtask

  // Asynchronous reset in the middle of SUMA
  task automatic test_reset_async();
    bit seen;
    @(negedge clk);
    cociente = 4'd3; divisor = 4'd5; resto = 4'd2; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dividendo, ocupado, listo, error} !== 11'd0) begin
      errors++;
      $display("FAIL reset_async_outputs: got div=%0d ocu=%b lis=%b err=%b, need all 0",
               dividendo, ocupado, listo, error);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (listo || ocupado) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_async_no_listo: got activity after reset, need none");
    end
    test_op("post_reset", 4'd1, 4'd1, 4'd0, 8'd1);
  endtask

  // Exhaustive sweep of every (q, d, r) tuple
  task automatic test_barrido();
    int lat;
    bit ok;
    logic [2*N-1:0] exp_div;
    for (int q = 0; q < 16; q++) begin
      for (int d = 0; d < 16; d++) begin
        for (int r = 0; r < 16; r++) begin
          run_op(4'(q), 4'(d), 4'(r), lat, ok);
          exp_div = 8'(q * d + r);
          checks++;
          if (!ok || dividendo !== exp_div || error !== exp_err(4'(r), 4'(d))) begin
            errors++;
            $display("FAIL barrido q=%0d d=%0d r=%0d: got ok=%0d div=%0d err=%b, need div=%0d err=%b",
                     q, d, r, ok, dividendo, error, exp_div, exp_err(4'(r), 4'(d)));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basico();
    test_op("max", 4'd15, 4'd15, 4'd14, 8'd239);
    test_op("cero", 4'd0, 4'd0, 4'd0, 8'd0);
    test_op("cero_resto7", 4'd0, 4'd4, 4'd7, 8'd7);
    test_back_to_back();
    test_reset_async();
    test_barrido();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
